// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_pkg
// Description : Shared types and constants for the nibble-serial adder
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index counter width; a single-nibble build still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder_4.sv
`default_nettype none
// ============================================================================
// Module      : adder_4
// Description : 4-bit ripple adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule : adder_4
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_ctrl
// Description : Performs one NIBBLES*4-bit add/subtract by stepping a single
//               shared 4-bit adder across the operand, LS nibble first.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        op_sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int             IW         = idx_width(NIBBLES);
    localparam logic [IW-1:0]  C_LAST_IDX = IW'(NIBBLES - 1);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [IW-1:0]                       r_idx;
    logic                                r_carry;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]    r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]    r_b_eff;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]    r_sum;
    logic                                r_done;
    logic                                r_cout;
    logic                                r_ovf;

    logic [NIBBLE_W-1:0]                 w_sum_nib;
    logic                                w_cout;
    logic                                w_last;

    assign w_last = (r_idx == C_LAST_IDX);

    adder_4 u_adder_4 (
        .A    (r_a[r_idx]),
        .B    (r_b_eff[r_idx]),
        .Cin  (r_carry),
        .Sum  (w_sum_nib),
        .Cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1, so the inversion and forced carry happen at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b_eff <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_a     <= a;
                    r_b_eff <= op_sub ? ~b : b;
                    r_carry <= op_sub ? 1'b1 : cin;
                    r_idx   <= '0;
                end
            end else begin
                r_sum[r_idx] <= w_sum_nib;
                r_carry      <= w_cout;
                r_idx        <= r_idx + 1'b1;
                if (w_last) begin
                    r_idx  <= '0;
                    r_done <= 1'b1;
                    r_cout <= w_cout;
                    r_ovf  <= (r_a[NIBBLES-1][NIBBLE_W-1] == r_b_eff[NIBBLES-1][NIBBLE_W-1]) &&
                              (w_sum_nib[NIBBLE_W-1] != r_a[NIBBLES-1][NIBBLE_W-1]);
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : adder_seq_ctrl
`default_nettype wire
